// File: rtl/ddr_rdwr_arbiter_pkg.sv
// Shared types and constants for the DDR3 frame-buffer read/write arbiter.
// The state encoding and range constants are also reused by the write/read
// logic wrappers when they check their side of the handshake.
package ddr_rdwr_arbiter_pkg;

    // Counter widths
    localparam int unsigned GAP_CNT_W = 4;
    localparam int unsigned WD_CNT_W  = 8;

    // Legal parameter ranges
    localparam int unsigned GAP_MIN     = 1;
    localparam int unsigned GAP_MAX     = 15;
    localparam int unsigned TIMEOUT_MIN = 2;
    localparam int unsigned TIMEOUT_MAX = 255;

    // One-hot arbiter states
    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_WR_ACK  = 6'b000010,
        ST_WR_BUSY = 6'b000100,
        ST_RD_ACK  = 6'b001000,
        ST_RD_BUSY = 6'b010000,
        ST_GAP     = 6'b100000
    } arb_state_e;

    // Clamp a configuration value into [lo, hi]
    function automatic int unsigned clamp_u(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/ddr_rdwr_arbiter.sv
// ddr_rdwr_arbiter: grants the single MCB-backed DDR3 frame buffer to either
// the write logic or the read logic, one owner at a time.
//
// Ports:
//   clk           frame-buffer clock
//   reset_n       asynchronous active-low reset
//   i_calib_done  MCB calibration done; no new grant while low
//   i_wr_req      write request (level, held until ack)
//   o_wr_ack      write acknowledge, one-cycle pulse
//   i_writing     write logic busy
//   i_rd_req      read request (level, held until ack)
//   o_rd_ack      read acknowledge, one-cycle pulse
//   i_reading     read logic busy
//   o_wr_owner    write side holds the grant (ACK through BUSY)
//   o_rd_owner    read side holds the grant
//   o_timeout_err sticky: a granted side never raised busy in time
module ddr_rdwr_arbiter
    import ddr_rdwr_arbiter_pkg::*;
#(
    parameter string       WR_PRIORITY    = "FALSE",
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_calib_done,
    input  logic i_wr_req,
    output logic o_wr_ack,
    input  logic i_writing,
    input  logic i_rd_req,
    output logic o_rd_ack,
    input  logic i_reading,
    output logic o_wr_owner,
    output logic o_rd_owner,
    output logic o_timeout_err
);

    localparam bit          WR_PRIO = (WR_PRIORITY == "TRUE");
    localparam int unsigned GAP_EFF = clamp_u(GAP_CYCLES, GAP_MIN, GAP_MAX);
    localparam int unsigned TO_EFF  = clamp_u(TIMEOUT_CYCLES, TIMEOUT_MIN, TIMEOUT_MAX);

    // Terminal counts: GAP lasts GAP_EFF cycles, ACK waits TO_EFF cycles
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_EFF - 1);
    localparam logic [WD_CNT_W-1:0]  WD_LAST  = WD_CNT_W'(TO_EFF - 1);

    arb_state_e            state_q, state_d;
    logic                  last_wr_q, last_wr_d;   // 1 = write was granted last
    logic [GAP_CNT_W-1:0]  gap_q, gap_d;
    logic [WD_CNT_W-1:0]   wd_q, wd_d;
    logic                  err_q, err_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  wr_own_q, wr_own_d;
    logic                  rd_own_q, rd_own_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
            gap_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_own_q  <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            wr_own_q  <= wr_own_d;
            rd_own_q  <= rd_own_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        gap_d     = gap_q;
        wd_d      = wd_q;
        err_d     = err_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_calib_done) begin
                    // Write wins when alone, under priority, or when read went last
                    if (i_wr_req && (!i_rd_req || WR_PRIO || !last_wr_q)) begin
                        state_d   = ST_WR_ACK;
                        wr_ack_d  = 1'b1;
                        last_wr_d = 1'b1;
                        wd_d      = '0;
                    end else if (i_rd_req) begin
                        state_d   = ST_RD_ACK;
                        rd_ack_d  = 1'b1;
                        last_wr_d = 1'b0;
                        wd_d      = '0;
                    end
                end
            end
            ST_WR_ACK: begin
                if (i_writing) begin
                    state_d = ST_WR_BUSY;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_CNT_W'(1);
                end
            end
            ST_WR_BUSY: begin
                if (!i_writing) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_RD_ACK: begin
                if (i_reading) begin
                    state_d = ST_RD_BUSY;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_CNT_W'(1);
                end
            end
            ST_RD_BUSY: begin
                if (!i_reading) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                // Requests are not looked at until the gap has fully elapsed
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_own_d = (state_d == ST_WR_ACK) || (state_d == ST_WR_BUSY);
        rd_own_d = (state_d == ST_RD_ACK) || (state_d == ST_RD_BUSY);
    end

    assign o_wr_ack      = wr_ack_q;
    assign o_rd_ack      = rd_ack_q;
    assign o_wr_owner    = wr_own_q;
    assign o_rd_owner    = rd_own_q;
    assign o_timeout_err = err_q;

endmodule

// File: tb/tb_ddr_rdwr_arbiter.sv
// Bench for ddr_rdwr_arbiter: instance A is round-robin, instance B is
// write-priority. Expected acks (side + cycle) are queued when requests are
// driven and retired by a monitor when the DUT pulses an ack.
module tb_ddr_rdwr_arbiter;

    typedef struct {
        bit is_wr;
        int cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    logic calib;
    int   cyc;
    int   checks;
    int   failures;

    // Instance A (round-robin)
    logic a_wr_req, a_writing, a_rd_req, a_reading;
    logic a_wr_ack, a_rd_ack, a_wr_owner, a_rd_owner, a_err;
    // Instance B (write priority)
    logic b_wr_req, b_writing, b_rd_req, b_reading;
    logic b_wr_ack, b_rd_ack, b_wr_owner, b_rd_owner, b_err;

    exp_t q_a[$];
    exp_t q_b[$];

    ddr_rdwr_arbiter #(
        .WR_PRIORITY    ("FALSE"),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) u_dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_calib_done  (calib),
        .i_wr_req      (a_wr_req),
        .o_wr_ack      (a_wr_ack),
        .i_writing     (a_writing),
        .i_rd_req      (a_rd_req),
        .o_rd_ack      (a_rd_ack),
        .i_reading     (a_reading),
        .o_wr_owner    (a_wr_owner),
        .o_rd_owner    (a_rd_owner),
        .o_timeout_err (a_err)
    );

    ddr_rdwr_arbiter #(
        .WR_PRIORITY    ("TRUE"),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) u_dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_calib_done  (calib),
        .i_wr_req      (b_wr_req),
        .o_wr_ack      (b_wr_ack),
        .i_writing     (b_writing),
        .i_rd_req      (b_rd_req),
        .o_rd_ack      (b_rd_ack),
        .i_reading     (b_reading),
        .o_wr_owner    (b_wr_owner),
        .o_rd_owner    (b_rd_owner),
        .o_timeout_err (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_a(input bit is_wr, input int at);
        exp_t e;
        e.is_wr = is_wr;
        e.cyc   = at;
        q_a.push_back(e);
    endtask

    task automatic push_b(input bit is_wr, input int at);
        exp_t e;
        e.is_wr = is_wr;
        e.cyc   = at;
        q_b.push_back(e);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_a"}, 32'({a_wr_ack, a_rd_ack, a_wr_owner, a_rd_owner, a_err}), 32'd0);
        chk({tag, "_b"}, 32'({b_wr_ack, b_rd_ack, b_wr_owner, b_rd_owner, b_err}), 32'd0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_low("reset_outs");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard monitor for instance A
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() != 0 && q_a[0].cyc < cyc) begin
            e = q_a.pop_front();
            chk("a_missed_ack", 32'(cyc), 32'(e.cyc));
        end
        if (a_wr_ack || a_rd_ack) begin
            if (q_a.size() == 0) begin
                chk("a_unexp_ack", 32'({a_wr_ack, a_rd_ack}), 32'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_ack_side_wr", 32'(a_wr_ack), 32'(e.is_wr));
                chk("a_ack_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        chk("a_mutex", 32'(a_wr_owner & a_rd_owner), 32'd0);
        chk("a_ack_xown", 32'((a_wr_ack & a_rd_owner) | (a_rd_ack & a_wr_owner)), 32'd0);
    end

    // Scoreboard monitor for instance B
    always @(negedge clk) begin
        exp_t e;
        if (q_b.size() != 0 && q_b[0].cyc < cyc) begin
            e = q_b.pop_front();
            chk("b_missed_ack", 32'(cyc), 32'(e.cyc));
        end
        if (b_wr_ack || b_rd_ack) begin
            if (q_b.size() == 0) begin
                chk("b_unexp_ack", 32'({b_wr_ack, b_rd_ack}), 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_ack_side_wr", 32'(b_wr_ack), 32'(e.is_wr));
                chk("b_ack_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        chk("b_mutex", 32'(b_wr_owner & b_rd_owner), 32'd0);
    end

    initial begin
        int base;
        int a;
        int r;
        int i;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        calib    = 1'b0;
        a_wr_req = 1'b0; a_writing = 1'b0; a_rd_req = 1'b0; a_reading = 1'b0;
        b_wr_req = 1'b0; b_writing = 1'b0; b_rd_req = 1'b0; b_reading = 1'b0;

        apply_reset();
        chk_all_low("post_reset");

        // Single write, then a read raised during GAP is held off
        calib = 1'b1;
        base  = cyc;
        wait_to(base + 5);
        a_wr_req = 1'b1;
        push_a(1'b1, base + 6);
        wait_to(base + 6);
        a_wr_req = 1'b0;
        chk("t1_owner_at_ack", 32'(a_wr_owner), 32'd1);
        wait_to(base + 8);
        a_writing = 1'b1;
        wait_to(base + 19);
        chk("t1_owner_busy", 32'(a_wr_owner), 32'd1);
        wait_to(base + 20);
        a_writing = 1'b0;
        chk("t1_owner_at_fall", 32'(a_wr_owner), 32'd1);
        wait_to(base + 21);
        chk("t1_owner_low", 32'(a_wr_owner), 32'd0);
        a_rd_req = 1'b1;
        push_a(1'b0, base + 24);
        wait_to(base + 23);
        chk("t1_gap_no_owner", 32'({a_wr_owner, a_rd_owner}), 32'd0);
        wait_to(base + 24);
        a_rd_req = 1'b0;
        wait_to(base + 25);
        a_reading = 1'b1;
        wait_to(base + 26);
        a_reading = 1'b0;
        wait_to(base + 30);

        // Round-robin ties
        apply_reset();
        base = cyc;
        a_wr_req = 1'b1;
        a_rd_req = 1'b1;
        push_a(1'b1, base + 1);
        wait_to(base + 1);
        a_wr_req = 1'b0;
        wait_to(base + 2);
        a_writing = 1'b1;
        wait_to(base + 5);
        a_writing = 1'b0;
        wait_to(base + 6);
        a_wr_req = 1'b1;
        push_a(1'b0, base + 9);
        wait_to(base + 8);
        chk("t2_rd_held_off", 32'(a_rd_owner), 32'd0);
        wait_to(base + 9);
        a_rd_req = 1'b0;
        push_a(1'b1, base + 16);
        wait_to(base + 10);
        a_reading = 1'b1;
        wait_to(base + 12);
        a_reading = 1'b0;
        chk("t2_rd_owner_fall", 32'(a_rd_owner), 32'd1);
        wait_to(base + 13);
        chk("t2_rd_owner_low", 32'(a_rd_owner), 32'd0);
        wait_to(base + 16);
        a_wr_req = 1'b0;
        wait_to(base + 17);
        a_writing = 1'b1;
        wait_to(base + 18);
        a_writing = 1'b0;
        wait_to(base + 21);

        // Read grant times out
        base = cyc;
        a_rd_req = 1'b1;
        a = base + 1;
        push_a(1'b0, a);
        wait_to(a);
        a_rd_req = 1'b0;
        wait_to(a + 15);
        chk("t3_owner_before_to", 32'(a_rd_owner), 32'd1);
        chk("t3_err_before_to", 32'(a_err), 32'd0);
        wait_to(a + 16);
        chk("t3_owner_at_to", 32'(a_rd_owner), 32'd0);
        chk("t3_err_at_to", 32'(a_err), 32'd1);
        a_wr_req = 1'b1;
        push_a(1'b1, a + 19);
        wait_to(a + 19);
        a_wr_req = 1'b0;
        chk("t3_err_sticky", 32'(a_err), 32'd1);
        wait_to(a + 20);
        a_writing = 1'b1;
        wait_to(a + 21);
        a_writing = 1'b0;
        wait_to(a + 24);
        chk("t3_err_still", 32'(a_err), 32'd1);

        // Calibration gate, then reset during WR_BUSY
        calib = 1'b0;
        apply_reset();
        base = cyc;
        a_wr_req = 1'b1;
        a_rd_req = 1'b1;
        wait_to(base + 100);
        chk("t4_no_grant_uncal", 32'({a_wr_owner, a_rd_owner}), 32'd0);
        calib = 1'b1;
        push_a(1'b1, base + 101);
        wait_to(base + 101);
        a_wr_req = 1'b0;
        calib    = 1'b0;
        wait_to(base + 102);
        a_writing = 1'b1;
        wait_to(base + 104);
        chk("t4_grant_survives_cal", 32'(a_wr_owner), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_low("t4_async_reset");
        a_writing = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        calib   = 1'b1;
        r = cyc;
        push_a(1'b0, r + 1);
        wait_to(r + 1);
        a_rd_req = 1'b0;
        chk("t4_rd_owner", 32'(a_rd_owner), 32'd1);
        wait_to(r + 2);
        a_reading = 1'b1;
        wait_to(r + 3);
        a_reading = 1'b0;
        wait_to(r + 6);

        // Write priority: write wins every tie while it keeps requesting
        b_wr_req = 1'b1;
        b_rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i = cyc;
            push_b(1'b1, i + 1);
            wait_to(i + 1);
            b_wr_req = 1'b0;
            chk("t5_wr_owner", 32'(b_wr_owner), 32'd1);
            wait_to(i + 2);
            b_writing = 1'b1;
            wait_to(i + 4);
            b_writing = 1'b0;
            wait_to(i + 5);
            if (k < 2) b_wr_req = 1'b1;
            else       b_rd_req = 1'b0;
            wait_to(i + 7);
        end
        chk("t5_rd_never_owner", 32'(b_rd_owner), 32'd0);

        repeat (4) @(negedge clk);
        chk("a_pending_acks", 32'(q_a.size()), 32'd0);
        chk("b_pending_acks", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
